// File: rtl/core_mem_arbiter_pkg.sv
// Shared memory-bundle types for the core/memory boundary and the arbiter's owner tag.
package core_mem_arbiter_pkg;

  // Physical width of the bundle fields; arbiter ADDR_W/DATA_W must not exceed these.
  localparam int unsigned BusAddrW = 32;
  localparam int unsigned BusDataW = 32;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } MemFcn;

  // Access size codes, carried through to the backing memory untouched.
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd4;
  localparam logic [2:0] MT_HU = 3'd5;

  typedef enum logic {
    IMEM = 1'b0,
    DMEM = 1'b1
  } ArbOwner;

  typedef struct packed {
    logic                req_valid;
    logic [BusAddrW-1:0] req_addr;
    logic [BusDataW-1:0] req_data;
    MemFcn               req_fcn;
    logic [2:0]          req_typ;
  } MemoryIn;

  typedef struct packed {
    logic                req_ready;
    logic                resp_valid;
    logic [BusDataW-1:0] resp_data;
  } MemoryOut;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data ports, with the fetch starvation counter.
// grant[0] selects imem, grant[1] selects dmem; both are zero unless idle.
module mem_arb_prio #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       imem_valid,
  input  logic       dmem_valid,
  input  logic       idle,
  output logic [1:0] grant
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            imem_win, dmem_win;

  // Dmem has priority unless fetch has already been passed over STARVE_MAX times in a row.
  always_comb begin
    imem_win = idle && imem_valid && (!dmem_valid || (starve_cnt_q == CntMax));
    dmem_win = idle && dmem_valid && !imem_win;
    grant    = {dmem_win, imem_win};
  end

  // Count dmem grants that bypassed a waiting fetch; any other grant resets the streak.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (imem_win) begin
      starve_cnt_d = '0;
    end else if (dmem_win) begin
      if (!imem_valid) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != CntMax) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Merges instruction-fetch and data ports onto one single-ported memory with one
// transaction in flight; the response is routed back to the port that won the grant.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  MemoryIn           imem_in,
  output MemoryOut          imem_out,
  input  MemoryIn           dmem_in,
  output MemoryOut          dmem_out,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              mem_req_fcn,
  output logic [2:0]        mem_req_typ,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e            state_q, state_d;
  ArbOwner           owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  MemFcn             fcn_q, fcn_d;
  logic [2:0]        typ_q, typ_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              proto_err_q, proto_err_d;
  logic              idle;
  logic [1:0]        grant;

  assign idle = (state_q == StIdle);

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .imem_valid (imem_in.req_valid),
    .dmem_valid (dmem_in.req_valid),
    .idle       (idle),
    .grant      (grant)
  );

  // Next-state: latch the winner's request at grant, then issue, wait, respond.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    data_d      = data_q;
    fcn_d       = fcn_q;
    typ_d       = typ_q;
    resp_data_d = resp_data_q;
    // A response outside WAIT has no owner; it is dropped and flagged for one cycle.
    proto_err_d = mem_resp_valid && (state_q != StWait);
    unique case (state_q)
      StIdle: begin
        if (grant[0]) begin
          owner_d = IMEM;
          addr_d  = imem_in.req_addr[ADDR_W-1:0];
          data_d  = imem_in.req_data[DATA_W-1:0];
          fcn_d   = imem_in.req_fcn;
          typ_d   = imem_in.req_typ;
          state_d = StIssue;
        end else if (grant[1]) begin
          owner_d = DMEM;
          addr_d  = dmem_in.req_addr[ADDR_W-1:0];
          data_d  = dmem_in.req_data[DATA_W-1:0];
          fcn_d   = dmem_in.req_fcn;
          typ_d   = dmem_in.req_typ;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_resp_valid) begin
          // Write acks carry no data; hand back zero rather than whatever is on the bus.
          resp_data_d = (fcn_q == M_XWR) ? '0 : mem_resp_data;
          state_d     = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and request/response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= IMEM;
      addr_q      <= '0;
      data_q      <= '0;
      fcn_q       <= M_XRD;
      typ_q       <= '0;
      resp_data_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      fcn_q       <= fcn_d;
      typ_q       <= typ_d;
      resp_data_q <= resp_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Port and downstream outputs; ready only on the grant cycle, resp_valid only to the owner.
  always_comb begin
    imem_out            = '0;
    dmem_out            = '0;
    imem_out.req_ready  = grant[0];
    dmem_out.req_ready  = grant[1];
    imem_out.resp_valid = (state_q == StResp) && (owner_q == IMEM);
    dmem_out.resp_valid = (state_q == StResp) && (owner_q == DMEM);
    imem_out.resp_data  = BusDataW'(resp_data_q);
    dmem_out.resp_data  = BusDataW'(resp_data_q);
    mem_req_valid       = (state_q == StIssue);
    mem_req_addr        = addr_q;
    mem_req_data        = data_q;
    mem_req_fcn         = fcn_q;
    mem_req_typ         = typ_q;
  end

  // Report downstream responses that arrive when nothing is outstanding.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mem_resp_valid && (state_q != StWait)))
        else $warning("core_mem_arbiter: mem_resp_valid outside WAIT ignored");
    end
  end

endmodule
